store_rmw_unit: RTL and testbench
=================================

# store_rmw_unit

Parametrised store sequencer between the core's memory stage and a single-port synchronous data RAM that has no byte enables. Full-width stores go straight to the RAM. Sub-word stores (byte, half, and word when D_WIDTH=64) run a read-modify-write sequence with a valid/ready handshake. Misaligned stores are flagged and never reach the RAM.

## Interface
- D_WIDTH, 32: RAM word width in bits; legal values 32 or 64.
- A_WIDTH, 32: byte address width.
- LANE_W (derived): log2(D_WIDTH/8), i.e. 2 for 32-bit, 3 for 64-bit.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  A_WIDTH  byte address of the store.
- req_addrmode  in  3  000 byte, 001 half, 010 word, 011 double; 1xx is treated as full-width.
- req_wdata  in  D_WIDTH  store data, right-aligned; only the low 8/16/32 bits are used for sub-word stores.
- ram_addr  out  A_WIDTH-LANE_W  RAM word address.
- ram_re  out  1  RAM read strobe; data appears on ram_rdata the next cycle.
- ram_rdata  in  D_WIDTH  RAM read data.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  D_WIDTH  RAM write data.
- done  out  1  one-cycle pulse when a store's RAM write is issued.
- misalign  out  1  one-cycle pulse when a store is rejected as misaligned.

## Operation
- A request is accepted when req_valid and req_ready are both high. Address, mode and data are captured into registers at acceptance; inputs are don't-care afterwards.
- Store size in bytes: 1 for mode 000, 2 for 001, 4 for 010. Modes 011 and 1xx are full-width, i.e. D_WIDTH/8 bytes; for D_WIDTH=32, 010 is also full-width.
- Lane = req_addr[LANE_W-1:0]. A store is misaligned when lane is not a multiple of its size; 1- and full-width stores use lane 0 only for full-width.
- Full-width stores also require lane = 0; otherwise the store is misaligned.
- State machine: IDLE, RD, WR, ERR.
  - IDLE: accepting a misaligned request goes to ERR.
  - IDLE: accepting an aligned full-width request goes to WR, with the merge bypassed.
  - IDLE: accepting an aligned sub-word request goes to RD.
  - IDLE: otherwise the unit stays in IDLE.
  - RD: ram_re=1, ram_addr = captured address word index; next state WR.
  - WR: ram_we=1, ram_addr as in RD, done=1; next state IDLE.
    - Full-width write data: ram_wdata = captured wdata.
    - Sub-word write data: ram_wdata = ram_rdata with bytes [lane, lane+size) replaced by the low size bytes of the captured wdata. The merge is combinational from ram_rdata.
  - ERR: misalign=1, with no RAM strobes; next state IDLE.
- ram_re and ram_we are never high in the same cycle. At most one request is in flight.
- Outputs are zero whenever not driven by the current state: ram_addr=0, ram_wdata=0, strobes=0.

## Timing
- Reset (asynchronous, rst_n low): state IDLE.
  - req_ready=1 once rst_n is high; it is held low while rst_n is low.
  - ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0, done=0, misalign=0.
  - All capture registers are cleared to 0.
- Reset asserted during RD or WR aborts the store: no write is issued, and the request is lost.
- Latency, with the request accepted at cycle T:
  - Sub-word: ram_re at T+1; ram_we and done at T+2; req_ready high at T+3.
  - Full-width: ram_we and done at T+1; req_ready high at T+2.
  - Misaligned: misalign at T+1; req_ready high at T+2.
- Throughput: a new request can be accepted in the first IDLE cycle after WR/ERR. This gives one sub-word store every 3 cycles and one full-width store every 2 cycles.
- req_valid held high while req_ready=0 is legal; the request is accepted on the next IDLE cycle.
- ram_rdata is sampled only in WR of a sub-word store; its value in other cycles is ignored.

## Test plan
- D_WIDTH=32, RAM[0x40]=0x11223344, byte store addr 0x102, wdata 0x000000AB -> T+1: ram_re=1, ram_addr=0x40; T+2: ram_we=1, ram_wdata=0x11AB3344, done=1.
- D_WIDTH=32, same RAM word, half store addr 0x102, wdata 0xCAFEBEEF -> T+2: ram_wdata=0xBEEF3344.
- D_WIDTH=32, half store addr 0x103 and word store addr 0x101 -> misalign pulse at T+1; ram_re and ram_we stay 0 for both.
- D_WIDTH=32, word store addr 0x100, wdata 0xDEADBEEF -> T+1: ram_we=1, ram_wdata=0xDEADBEEF, done=1; ram_re never asserted. With req_valid held high, the next request is accepted at T+2.
- D_WIDTH=64, RAM word = 0x0011223344556677, word store addr 0x4, wdata 0x89ABCDEF -> T+2: ram_wdata=0x89ABCDEF44556677.
  - Double store to addr 0x4 -> misalign pulse at T+1.
- Sub-word store accepted at T, rst_n pulled low at T+1 for 1 cycle -> no ram_we ever; all outputs 0 during reset; req_ready=1 the cycle after rst_n rises.

Source files
------------

// File: rtl/store_rmw_unit_if.sv
// Store request channel between the core memory stage (master) and the
// store read-modify-write sequencer (slave).
interface store_rmw_unit_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [A_WIDTH-1:0] req_addr;
  logic [2:0]         req_addrmode;
  logic [D_WIDTH-1:0] req_wdata;

  modport master (
    output req_valid, req_addr, req_addrmode, req_wdata,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_addrmode, req_wdata,
    output req_ready
  );
endinterface

// File: rtl/store_rmw_unit.sv
// Store sequencer in front of a single-port RAM without byte enables.
// Full-width stores write directly; sub-word stores read the word, merge
// the new bytes over it and write it back. Misaligned stores are rejected
// with a one-cycle misalign pulse and never touch the RAM.
module store_rmw_unit #(
  parameter  int D_WIDTH = 32,
  parameter  int A_WIDTH = 32,
  localparam int LANE_W  = $clog2(D_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  store_rmw_unit_if.slave           req,
  output logic [A_WIDTH-LANE_W-1:0] ram_addr,
  output logic                      ram_re,
  input  logic [D_WIDTH-1:0]        ram_rdata,
  output logic                      ram_we,
  output logic [D_WIDTH-1:0]        ram_wdata,
  output logic                      done,
  output logic                      misalign
);

  localparam int NB = D_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Byte counts encoded in LANE_W+1 bits (1, 2, 4 and the full word).
  localparam logic [LANE_W:0] NB_BYTE = {{LANE_W{1'b0}}, 1'b1};
  localparam logic [LANE_W:0] NB_HALF = {{(LANE_W-1){1'b0}}, 2'b10};
  localparam logic [LANE_W:0] NB_WORD = {2'b01, {(LANE_W-1){1'b0}}};
  localparam logic [LANE_W:0] NB_FULL = {1'b1, {LANE_W{1'b0}}};

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic [A_WIDTH-1:0]        addr_r;
  logic [D_WIDTH-1:0]        wdata_r;
  logic                      full_r;
  logic [LANE_W:0]           nbytes_r;

  logic                      ready_s;
  logic                      accept_s;
  logic [LANE_W-1:0]         lane_s;
  logic [LANE_W:0]           nbytes_s;
  logic                      full_s;
  logic                      mis_s;
  logic [A_WIDTH-1:0]        addr_nxt_s;
  logic [D_WIDTH-1:0]        mask_s;
  logic [D_WIDTH-1:0]        merge_s;

  logic                      ram_re_r;
  logic                      ram_we_r;
  logic                      done_r;
  logic                      misalign_r;
  logic [A_WIDTH-LANE_W-1:0] ram_addr_r;

  // Byte-lane mask covering bytes [lane, lane+nbytes) of a RAM word.
  function automatic logic [D_WIDTH-1:0] byte_mask(input logic [LANE_W-1:0] lane,
                                                   input logic [LANE_W:0]   nbytes);
    logic [D_WIDTH-1:0] m;
    int                 lo;
    int                 hi;
    m  = {D_WIDTH{1'b0}};
    lo = int'(lane);
    hi = lo + int'(nbytes);
    for (int i = 0; i < NB; i++) begin
      if (i >= lo && i < hi) m[8*i +: 8] = 8'hFF;
      else                   m[8*i +: 8] = 8'h00;
    end
    return m;
  endfunction

  // Ready is forced low while reset is asserted, even though state is IDLE.
  assign ready_s       = rst_n & (state_r == ST_IDLE);
  assign accept_s      = req.req_valid & ready_s;
  assign req.req_ready = ready_s;

  // Decode store size, full-width flag and alignment of the incoming request.
  always_comb begin
    lane_s = req.req_addr[LANE_W-1:0];
    case (req.req_addrmode)
      3'b000:  nbytes_s = NB_BYTE;
      3'b001:  nbytes_s = NB_HALF;
      3'b010: begin
        if (D_WIDTH == 64) nbytes_s = NB_WORD;
        else               nbytes_s = NB_FULL;
      end
      default: nbytes_s = NB_FULL;
    endcase
    full_s = (nbytes_s == NB_FULL);
    mis_s  = (({1'b0, lane_s} & (nbytes_s - NB_BYTE)) != {(LANE_W+1){1'b0}});
  end

  // Next-state logic of the IDLE/RD/WR/ERR sequencer.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (mis_s)       state_nxt_s = ST_ERR;
          else if (full_s) state_nxt_s = ST_WR;
          else             state_nxt_s = ST_RD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD:   state_nxt_s = ST_WR;
      ST_WR:   state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Capture the request at acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r   <= {A_WIDTH{1'b0}};
      wdata_r  <= {D_WIDTH{1'b0}};
      full_r   <= 1'b0;
      nbytes_r <= {(LANE_W+1){1'b0}};
    end else if (accept_s) begin
      addr_r   <= req.req_addr;
      wdata_r  <= req.req_wdata;
      full_r   <= full_s;
      nbytes_r <= nbytes_s;
    end else begin
      addr_r   <= addr_r;
      wdata_r  <= wdata_r;
      full_r   <= full_r;
      nbytes_r <= nbytes_r;
    end
  end

  assign addr_nxt_s = accept_s ? req.req_addr : addr_r;

  // Strobes, pulses and RAM address registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_re_r   <= 1'b0;
      ram_we_r   <= 1'b0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      ram_addr_r <= {(A_WIDTH-LANE_W){1'b0}};
    end else begin
      ram_re_r   <= (state_nxt_s == ST_RD);
      ram_we_r   <= (state_nxt_s == ST_WR);
      done_r     <= (state_nxt_s == ST_WR);
      misalign_r <= (state_nxt_s == ST_ERR);
      if (state_nxt_s == ST_RD || state_nxt_s == ST_WR)
        ram_addr_r <= addr_nxt_s[A_WIDTH-1:LANE_W];
      else
        ram_addr_r <= {(A_WIDTH-LANE_W){1'b0}};
    end
  end

  // Merge the shifted store bytes over the word read back from the RAM.
  always_comb begin
    mask_s  = byte_mask(addr_r[LANE_W-1:0], nbytes_r);
    merge_s = (ram_rdata & ~mask_s) |
              ((wdata_r << {addr_r[LANE_W-1:0], 3'b000}) & mask_s);
    if (!ram_we_r)   ram_wdata = {D_WIDTH{1'b0}};
    else if (full_r) ram_wdata = wdata_r;
    else             ram_wdata = merge_s;
  end

  assign ram_re   = ram_re_r;
  assign ram_we   = ram_we_r;
  assign ram_addr = ram_addr_r;
  assign done     = done_r;
  assign misalign = misalign_r;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: a 32-bit and a 64-bit instance share stimulus;
// sel64 chooses which one receives req_valid and is observed. Expected
// RAM write data comes from a byte-addressed memory model.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_mode = 3'd0;
  logic [63:0] req_wdata = 64'd0;

  int vectors = 0;
  int errors  = 0;
  int we_cnt  = 0;

  logic [7:0] refb [int];

  store_rmw_unit_if #(.D_WIDTH(32), .A_WIDTH(32)) if32 ();
  store_rmw_unit_if #(.D_WIDTH(64), .A_WIDTH(32)) if64 ();

  assign if32.req_valid    = req_valid & ~sel64;
  assign if32.req_addr     = req_addr;
  assign if32.req_addrmode = req_mode;
  assign if32.req_wdata    = req_wdata[31:0];
  assign if64.req_valid    = req_valid & sel64;
  assign if64.req_addr     = req_addr;
  assign if64.req_addrmode = req_mode;
  assign if64.req_wdata    = req_wdata;

  logic [29:0] a32;  logic re32, we32, done32, mis32;
  logic [31:0] rd32, wd32;
  logic [28:0] a64;  logic re64, we64, done64, mis64;
  logic [63:0] rd64, wd64;

  store_rmw_unit #(.D_WIDTH(32), .A_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .req(if32), .ram_addr(a32), .ram_re(re32),
    .ram_rdata(rd32), .ram_we(we32), .ram_wdata(wd32), .done(done32), .misalign(mis32)
  );

  store_rmw_unit #(.D_WIDTH(64), .A_WIDTH(32)) u64 (
    .clk(clk), .rst_n(rst_n), .req(if64), .ram_addr(a64), .ram_re(re64),
    .ram_rdata(rd64), .ram_we(we64), .ram_wdata(wd64), .done(done64), .misalign(mis64)
  );

  always #5 clk = ~clk;

  function automatic int key(input logic s, input int baddr);
    return (s ? 32'h10000 : 0) + baddr;
  endfunction

  function automatic logic [63:0] word_at(input logic s, input int widx);
    logic [63:0] w;
    int          nb;
    int          k;
    nb = s ? 8 : 4;
    w  = 64'd0;
    for (int i = 0; i < nb; i++) begin
      k = key(s, widx * nb + i);
      if (refb.exists(k)) w[8*i +: 8] = refb[k];
      else                w[8*i +: 8] = 8'h00;
    end
    return w;
  endfunction

  // RAM models: return the reference contents one cycle after a read, noise otherwise.
  always @(posedge clk) begin
    if (re32) rd32 <= 32'(word_at(1'b0, int'(a32)));
    else      rd32 <= $urandom;
    if (re64) rd64 <= word_at(1'b1, int'(a64));
    else      rd64 <= {$urandom, $urandom};
  end

  // Count every RAM write issued by either instance.
  always @(posedge clk) begin
    if (we32 | we64) we_cnt <= we_cnt + 1;
  end

  logic [63:0] o_ready, o_re, o_we, o_addr, o_wdata, o_done, o_mis;
  always_comb begin
    o_ready = {63'd0, sel64 ? if64.req_ready : if32.req_ready};
    o_re    = {63'd0, sel64 ? re64 : re32};
    o_we    = {63'd0, sel64 ? we64 : we32};
    o_done  = {63'd0, sel64 ? done64 : done32};
    o_mis   = {63'd0, sel64 ? mis64 : mis32};
    o_addr  = sel64 ? {35'd0, a64} : {34'd0, a32};
    o_wdata = sel64 ? wd64 : {32'd0, wd32};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic s, input int widx, input logic [63:0] data);
    int nb;
    nb = s ? 8 : 4;
    for (int i = 0; i < nb; i++) refb[key(s, widx * nb + i)] = data[8*i +: 8];
  endtask

  task automatic commit(input logic s, input int baddr, input int size, input logic [63:0] wd);
    for (int i = 0; i < size; i++) refb[key(s, baddr + i)] = wd[8*i +: 8];
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_re"}, o_re, 64'd0);
    check({tag, "_we"}, o_we, 64'd0);
    check({tag, "_addr"}, o_addr, 64'd0);
    check({tag, "_wdata"}, o_wdata, 64'd0);
    check({tag, "_done"}, o_done, 64'd0);
    check({tag, "_mis"}, o_mis, 64'd0);
  endtask

  // One complete store on the selected instance, checked cycle by cycle.
  task automatic run_store(input logic [31:0] addr, input logic [2:0] mode,
                           input logic [63:0] wd, output logic [63:0] got);
    int          nb, size, lane;
    logic        mis, full;
    logic [63:0] expw;
    nb   = sel64 ? 8 : 4;
    if (mode == 3'd0)                 size = 1;
    else if (mode == 3'd1)            size = 2;
    else if (mode == 3'd2 && nb == 8) size = 4;
    else                              size = nb;
    full = (size == nb);
    lane = int'(addr) % nb;
    mis  = (int'(addr) % size) != 0;
    expw = word_at(sel64, int'(addr) / nb);
    for (int i = 0; i < size; i++) expw[8*(lane + i) +: 8] = wd[8*i +: 8];
    got = 64'd0;
    @(negedge clk);
    check("ready_idle", o_ready, 64'd1);
    req_valid = 1'b1; req_addr = addr; req_mode = mode; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = $urandom; req_mode = 3'($urandom_range(7, 0));
    req_wdata = {$urandom, $urandom};
    @(negedge clk);
    check("busy_ready", o_ready, 64'd0);
    if (mis) begin
      check("mis_pulse", o_mis, 64'd1);
      check("mis_re", o_re, 64'd0);
      check("mis_we", o_we, 64'd0);
    end else if (full) begin
      check("full_we", o_we, 64'd1);
      check("full_re", o_re, 64'd0);
      check("full_done", o_done, 64'd1);
      check("full_addr", o_addr, 64'(int'(addr) / nb));
      check("full_wdata", o_wdata, expw);
      got = o_wdata;
    end else begin
      check("rd_re", o_re, 64'd1);
      check("rd_we", o_we, 64'd0);
      check("rd_done", o_done, 64'd0);
      check("rd_addr", o_addr, 64'(int'(addr) / nb));
    end
    @(negedge clk);
    if (mis || full) begin
      check("after_ready", o_ready, 64'd1);
      check_quiet("after");
    end else begin
      check("wr_we", o_we, 64'd1);
      check("wr_re", o_re, 64'd0);
      check("wr_done", o_done, 64'd1);
      check("wr_addr", o_addr, 64'(int'(addr) / nb));
      check("wr_wdata", o_wdata, expw);
      got = o_wdata;
      @(negedge clk);
      check("sub_ready", o_ready, 64'd1);
      check_quiet("sub_after");
    end
    if (!mis) commit(sel64, int'(addr), size, wd);
  endtask

  logic [63:0] got;
  int          we_before;

  initial begin
    for (int w = 0; w < 128; w++) preload(1'b0, w, {32'd0, $urandom});
    for (int w = 0; w < 64; w++)  preload(1'b1, w, {$urandom, $urandom});

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    sel64 = 1'b0; #1;
    check("rst32_ready", o_ready, 64'd0);
    check_quiet("rst32");
    sel64 = 1'b1; #1;
    check("rst64_ready", o_ready, 64'd0);
    check_quiet("rst64");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst64_ready", o_ready, 64'd1);
    sel64 = 1'b0; #1;
    check("post_rst32_ready", o_ready, 64'd1);

    // Directed 32-bit cases.
    preload(1'b0, 32'h40, 64'h11223344);
    run_store(32'h102, 3'b000, 64'h000000AB, got);
    check("tp_byte", got, 64'h11AB3344);
    preload(1'b0, 32'h40, 64'h11223344);
    run_store(32'h102, 3'b001, 64'hCAFEBEEF, got);
    check("tp_half", got, 64'hBEEF3344);
    we_before = we_cnt;
    run_store(32'h103, 3'b001, 64'h1234, got);
    run_store(32'h101, 3'b010, 64'h5678, got);
    check("tp_mis_no_we", 64'(we_cnt - we_before), 64'd0);
    run_store(32'h100, 3'b010, 64'hDEADBEEF, got);
    check("tp_word", got, 64'hDEADBEEF);

    // Back-to-back: req_valid stays high across a full-width store.
    preload(1'b0, 32'h41, 64'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h100; req_mode = 3'b010; req_wdata = 64'hDEADBEEF;
    @(posedge clk);
    #1 req_addr = 32'h104; req_mode = 3'b000; req_wdata = 64'h5A;
    @(negedge clk);
    check("b2b_we", o_we, 64'd1);
    check("b2b_wdata", o_wdata, 64'hDEADBEEF);
    check("b2b_busy", o_ready, 64'd0);
    @(negedge clk);
    check("b2b_ready", o_ready, 64'd1);
    check_quiet("b2b_idle");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_re", o_re, 64'd1);
    check("b2b_addr", o_addr, 64'h41);
    @(negedge clk);
    check("b2b_wdata2", o_wdata, 64'h1122335A);
    commit(1'b0, 32'h100, 4, 64'hDEADBEEF);
    commit(1'b0, 32'h104, 1, 64'h5A);

    // Directed 64-bit cases.
    sel64 = 1'b1;
    preload(1'b1, 0, 64'h0011223344556677);
    run_store(32'h4, 3'b010, 64'h89ABCDEF, got);
    check("tp64_word", got, 64'h89ABCDEF44556677);
    run_store(32'h4, 3'b011, 64'h0123456789ABCDEF, got);
    run_store(32'h0, 3'b100, 64'h0123456789ABCDEF, got);
    check("tp64_full", got, 64'h0123456789ABCDEF);

    // Randomized stores against the byte-memory model.
    for (int n = 0; n < 80; n++) begin
      sel64 = 1'($urandom_range(1, 0));
      run_store(32'h100 + 32'($urandom_range(127, 0)), 3'($urandom_range(7, 0)),
                {$urandom, $urandom}, got);
    end

    // Reset during RD aborts the store.
    sel64 = 1'b0;
    we_before = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h108; req_mode = 3'b000; req_wdata = 64'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_re", o_re, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", o_ready, 64'd0);
    check_quiet("abort_async");
    @(negedge clk);
    check_quiet("abort_held");
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", o_ready, 64'd1);
    check_quiet("abort_idle");
    check("abort_no_we", 64'(we_cnt - we_before), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
